// File: rtl/wshb_arbiter_if.sv
// Single Wishbone classic link. "master" drives the request side, "slave" returns ack/data.
interface wshb_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_W-1:0]     adr;
  logic [DATA_W-1:0]     dat_ms;
  logic [DATA_W/8-1:0]   sel;
  logic                  ack;
  logic [DATA_W-1:0]     dat_sm;

  modport master (output cyc, stb, we, adr, dat_ms, sel, input ack, dat_sm);
  modport slave  (input cyc, stb, we, adr, dat_ms, sel, output ack, dat_sm);
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter with a per-grant ack budget in front of one slave.
// Optional statistics counters are enabled with `define WSHB_ARBITER_STATS_EN.
module wshb_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_ACKS = 64
) (
  input  logic            clk,
  input  logic            rst,
  wshb_arbiter_if.slave   m0,
  wshb_arbiter_if.slave   m1,
  wshb_arbiter_if.master  s,
  output logic [1:0]      gnt
`ifdef WSHB_ARBITER_STATS_EN
  ,
  output logic [31:0]     m0_ack_cnt,
  output logic [31:0]     m1_ack_cnt,
  output logic [15:0]     switch_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_ACKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ACKS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_last;      // 1: master 1 was served last
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_ack_live;
  logic                 w_budget;
  logic                 w_preempt;

  logic                 w_cyc;
  logic                 w_stb;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_adr;
  logic [DATA_W-1:0]    w_dat_ms;
  logic [DATA_W/8-1:0]  w_sel;
  logic                 w_ack0;
  logic                 w_ack1;

  assign w_ack_live = s.ack && (r_state != IDLE);
  assign w_cnt_inc  = (w_ack_live && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
  assign w_budget   = (w_cnt_inc == CNT_MAX);

  // Pre-emption only at an ack edge or between strobes, so a classic cycle is never cut.
  always_comb begin
    w_next    = r_state;
    w_preempt = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || r_last))
          w_next = GNT0;
        else if (m1.cyc)
          w_next = GNT1;
      end
      GNT0: begin
        if (!m0.cyc) begin
          w_next = m1.cyc ? GNT1 : IDLE;
        end else if (w_budget && m1.cyc && (s.ack || !m0.stb)) begin
          w_next    = GNT1;
          w_preempt = 1'b1;
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          w_next = m0.cyc ? GNT0 : IDLE;
        end else if (w_budget && m0.cyc && (s.ack || !m1.stb)) begin
          w_next    = GNT0;
          w_preempt = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cyc    = 1'b0;
    w_stb    = 1'b0;
    w_we     = 1'b0;
    w_adr    = '0;
    w_dat_ms = '0;
    w_sel    = '0;
    w_ack0   = 1'b0;
    w_ack1   = 1'b0;
    case (r_state)
      GNT0: begin
        w_cyc    = m0.cyc;
        w_stb    = m0.stb;
        w_we     = m0.we;
        w_adr    = m0.adr;
        w_dat_ms = m0.dat_ms;
        w_sel    = m0.sel;
        w_ack0   = s.ack;
      end
      GNT1: begin
        w_cyc    = m1.cyc;
        w_stb    = m1.stb;
        w_we     = m1.we;
        w_adr    = m1.adr;
        w_dat_ms = m1.dat_ms;
        w_sel    = m1.sel;
        w_ack1   = s.ack;
      end
      default: ;
    endcase
  end

  assign s.cyc     = w_cyc;
  assign s.stb     = w_stb;
  assign s.we      = w_we;
  assign s.adr     = w_adr;
  assign s.dat_ms  = w_dat_ms;
  assign s.sel     = w_sel;
  assign m0.ack    = w_ack0;
  assign m1.ack    = w_ack1;
  assign m0.dat_sm = s.dat_sm;
  assign m1.dat_sm = s.dat_sm;
  assign gnt       = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0)
        r_last <= 1'b0;
      else if (w_next == GNT1)
        r_last <= 1'b1;
      r_cnt <= (w_next != r_state) ? '0 : w_cnt_inc;
    end
  end

`ifdef WSHB_ARBITER_STATS_EN
  logic [31:0] r_m0_ack_cnt;
  logic [31:0] r_m1_ack_cnt;
  logic [15:0] r_switch_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0_ack_cnt <= '0;
      r_m1_ack_cnt <= '0;
      r_switch_cnt <= '0;
    end else begin
      if (w_ack0)
        r_m0_ack_cnt <= r_m0_ack_cnt + 32'd1;
      if (w_ack1)
        r_m1_ack_cnt <= r_m1_ack_cnt + 32'd1;
      if (w_preempt)
        r_switch_cnt <= r_switch_cnt + 16'd1;
    end
  end

  assign m0_ack_cnt = r_m0_ack_cnt;
  assign m1_ack_cnt = r_m1_ack_cnt;
  assign switch_cnt = r_switch_cnt;
`endif

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter built with MAX_ACKS=4; statistics checks follow WSHB_ARBITER_STATS_EN.
module tb_wshb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] A0  = 32'h0000_1000;
  localparam logic [31:0] A1  = 32'h0000_2000;
  localparam logic [31:0] D0  = 32'hA0A0_0001;
  localparam logic [31:0] D1  = 32'h5555_AAAA;
  localparam logic [31:0] DSM = 32'hDEAD_BEEF;

  logic       clk;
  logic       rst;
  logic [1:0] gnt;
  int         n_pass;
  int         n_total;

  wshb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  wshb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  wshb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

`ifdef WSHB_ARBITER_STATS_EN
  logic [31:0] m0_ack_cnt;
  logic [31:0] m1_ack_cnt;
  logic [15:0] switch_cnt;
`endif

  wshb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_ACKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if),
    .gnt (gnt)
`ifdef WSHB_ARBITER_STATS_EN
    ,
    .m0_ack_cnt (m0_ack_cnt),
    .m1_ack_cnt (m1_ack_cnt),
    .switch_cnt (switch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input logic c0, input logic c1);
    m0_if.cyc = c0;
    m0_if.stb = c0;
    m1_if.cyc = c1;
    m1_if.stb = c1;
  endtask

  // Reset is released just after a rising edge; the following edge is edge 1.
  task automatic do_reset(input logic c0, input logic c1);
    rst = 1'b1;
    set_req(c0, c1);
    s_if.ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(1'b1, 1'b1);
    s_if.ack = 1'b1;
    #2;
    n_total++; if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b expected 00", gnt); else n_pass++;
    n_total++; if (s_if.cyc !== 1'b0) $display("FAIL rst_s_cyc: got %b expected 0", s_if.cyc); else n_pass++;
    n_total++; if (s_if.stb !== 1'b0) $display("FAIL rst_s_stb: got %b expected 0", s_if.stb); else n_pass++;
    n_total++; if (m0_if.ack !== 1'b0) $display("FAIL rst_m0_ack: got %b expected 0", m0_if.ack); else n_pass++;
    n_total++; if (m1_if.ack !== 1'b0) $display("FAIL rst_m1_ack: got %b expected 0", m1_if.ack); else n_pass++;
    n_total++; if (m1_if.dat_sm !== DSM) $display("FAIL rst_dat_sm: got %h expected %h", m1_if.dat_sm, DSM); else n_pass++;
`ifdef WSHB_ARBITER_STATS_EN
    n_total++; if (m0_ack_cnt !== 32'd0) $display("FAIL rst_m0_ack_cnt: got %0d expected 0", m0_ack_cnt); else n_pass++;
    n_total++; if (switch_cnt !== 16'd0) $display("FAIL rst_switch_cnt: got %0d expected 0", switch_cnt); else n_pass++;
`endif
  endtask

  task automatic test_single_master();
    do_reset(1'b1, 1'b0);
    s_if.ack = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
      n_total++; if (gnt !== 2'b01) $display("FAIL single_gnt k=%0d: got %b expected 01", k, gnt); else n_pass++;
      n_total++; if (m0_if.ack !== 1'b1) $display("FAIL single_m0_ack k=%0d: got %b expected 1", k, m0_if.ack); else n_pass++;
      n_total++; if (m1_if.ack !== 1'b0) $display("FAIL single_m1_ack k=%0d: got %b expected 0", k, m1_if.ack); else n_pass++;
      n_total++; if (s_if.adr !== A0) $display("FAIL single_s_adr k=%0d: got %h expected %h", k, s_if.adr, A0); else n_pass++;
    end
    n_total++; if (s_if.sel !== 4'hF) $display("FAIL single_s_sel: got %h expected f", s_if.sel); else n_pass++;
    n_total++; if (s_if.dat_ms !== D0) $display("FAIL single_s_dat: got %h expected %h", s_if.dat_ms, D0); else n_pass++;
    set_req(1'b0, 1'b0);
    @(posedge clk); #2;
    n_total++; if (gnt !== 2'b00) $display("FAIL release_gnt: got %b expected 00", gnt); else n_pass++;
    n_total++; if (m0_if.ack !== 1'b0) $display("FAIL idle_ack_ignored: got %b expected 0", m0_if.ack); else n_pass++;
    set_req(1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++; if (gnt !== 2'b10) $display("FAIL m1_only_gnt: got %b expected 10", gnt); else n_pass++;
    n_total++; if (s_if.we !== 1'b1) $display("FAIL m1_only_we: got %b expected 1", s_if.we); else n_pass++;
    n_total++; if (s_if.dat_ms !== D1) $display("FAIL m1_only_dat: got %h expected %h", s_if.dat_ms, D1); else n_pass++;
    n_total++; if (m1_if.ack !== 1'b1) $display("FAIL m1_only_ack: got %b expected 1", m1_if.ack); else n_pass++;
  endtask

  task automatic test_handover();
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      s_if.ack = 1'b1;
      #1;
      n_total++; if (gnt !== 2'b01) $display("FAIL hand_gnt k=%0d: got %b expected 01", k, gnt); else n_pass++;
      n_total++; if (m1_if.ack !== 1'b0) $display("FAIL hand_m1_ack k=%0d: got %b expected 0", k, m1_if.ack); else n_pass++;
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1);
    s_if.ack = 1'b0;
    #1;
    n_total++; if (gnt !== 2'b01) $display("FAIL hand_hold_gnt: got %b expected 01", gnt); else n_pass++;
    n_total++; if (s_if.cyc !== 1'b0) $display("FAIL hand_drop_cyc: got %b expected 0", s_if.cyc); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (gnt !== 2'b10) $display("FAIL hand_new_gnt: got %b expected 10", gnt); else n_pass++;
    n_total++; if (s_if.adr !== A1) $display("FAIL hand_new_adr: got %h expected %h", s_if.adr, A1); else n_pass++;
    n_total++; if (s_if.cyc !== 1'b1) $display("FAIL hand_new_cyc: got %b expected 1", s_if.cyc); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    int a0;
    int a1;
    a0 = 0;
    a1 = 0;
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      s_if.ack = 1'b1;
      if (k == 20) begin
        m1_if.cyc = 1'b0;
        m1_if.stb = 1'b0;
      end
      #1;
      eg = ((((k - 1) / 4) % 2) == 0) ? 2'b01 : 2'b10;
      if (m0_if.ack === 1'b1) a0++;
      if (m1_if.ack === 1'b1) a1++;
      n_total++; if (gnt !== eg) $display("FAIL rr_gnt k=%0d: got %b expected %b", k, gnt, eg); else n_pass++;
      n_total++; if (m0_if.ack !== eg[0]) $display("FAIL rr_m0_ack k=%0d: got %b expected %b", k, m0_if.ack, eg[0]); else n_pass++;
      n_total++; if (m1_if.ack !== eg[1]) $display("FAIL rr_m1_ack k=%0d: got %b expected %b", k, m1_if.ack, eg[1]); else n_pass++;
      n_total++; if (s_if.adr !== (eg[0] ? A0 : A1)) $display("FAIL rr_s_adr k=%0d: got %h expected %h", k, s_if.adr, eg[0] ? A0 : A1); else n_pass++;
    end
    @(posedge clk); #1;
    s_if.ack = 1'b0;
    #1;
    n_total++; if (gnt !== 2'b01) $display("FAIL rr_hold_gnt: got %b expected 01", gnt); else n_pass++;
    n_total++; if (a0 !== 12) $display("FAIL rr_m0_acks: got %0d expected 12", a0); else n_pass++;
    n_total++; if (a1 !== 8) $display("FAIL rr_m1_acks: got %0d expected 8", a1); else n_pass++;
`ifdef WSHB_ARBITER_STATS_EN
    n_total++; if (m0_ack_cnt !== 32'd12) $display("FAIL stats_m0_ack_cnt: got %0d expected 12", m0_ack_cnt); else n_pass++;
    n_total++; if (m1_ack_cnt !== 32'd8) $display("FAIL stats_m1_ack_cnt: got %0d expected 8", m1_ack_cnt); else n_pass++;
    n_total++; if (m0_ack_cnt + m1_ack_cnt !== 32'd20) $display("FAIL stats_ack_sum: got %0d expected 20", m0_ack_cnt + m1_ack_cnt); else n_pass++;
    n_total++; if (switch_cnt !== 16'd4) $display("FAIL stats_switch_cnt: got %0d expected 4", switch_cnt); else n_pass++;
`endif
  endtask

  task automatic test_slow_slave();
    logic [1:0] eg;
    logic       ak;
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      ak = ((k % 3) == 0);
      s_if.ack = ak;
      #1;
      eg = (k <= 12) ? 2'b01 : 2'b10;
      n_total++; if (gnt !== eg) $display("FAIL slow_gnt k=%0d: got %b expected %b", k, gnt, eg); else n_pass++;
      n_total++; if (m0_if.ack !== (eg[0] & ak)) $display("FAIL slow_m0_ack k=%0d: got %b expected %b", k, m0_if.ack, eg[0] & ak); else n_pass++;
      n_total++; if (m1_if.ack !== (eg[1] & ak)) $display("FAIL slow_m1_ack k=%0d: got %b expected %b", k, m1_if.ack, eg[1] & ak); else n_pass++;
      n_total++; if (s_if.stb !== 1'b1) $display("FAIL slow_s_stb k=%0d: got %b expected 1", k, s_if.stb); else n_pass++;
      n_total++; if (s_if.we !== eg[1]) $display("FAIL slow_s_we k=%0d: got %b expected %b", k, s_if.we, eg[1]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b1);
    s_if.ack = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    n_total++; if (gnt !== 2'b10) $display("FAIL mid_pre_gnt: got %b expected 10", gnt); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (gnt !== 2'b00) $display("FAIL mid_rst_gnt: got %b expected 00", gnt); else n_pass++;
    n_total++; if (s_if.cyc !== 1'b0) $display("FAIL mid_rst_cyc: got %b expected 0", s_if.cyc); else n_pass++;
    n_total++; if (s_if.stb !== 1'b0) $display("FAIL mid_rst_stb: got %b expected 0", s_if.stb); else n_pass++;
    n_total++; if (m1_if.ack !== 1'b0) $display("FAIL mid_rst_ack: got %b expected 0", m1_if.ack); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #2;
    n_total++; if (gnt !== 2'b01) $display("FAIL mid_regrant_a: got %b expected 01", gnt); else n_pass++;
    // Master 0 was just served; only a reset of last-served makes it win again.
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (gnt !== 2'b00) $display("FAIL mid_rst2_gnt: got %b expected 00", gnt); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #2;
    n_total++; if (gnt !== 2'b01) $display("FAIL mid_regrant_b: got %b expected 01", gnt); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
    m0_if.adr = A0;   m0_if.dat_ms = D0; m0_if.sel = 4'hF;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b1;
    m1_if.adr = A1;   m1_if.dat_ms = D1; m1_if.sel = 4'h3;
    s_if.ack    = 1'b0;
    s_if.dat_sm = DSM;
    test_reset();
    test_single_master();
    test_handover();
    test_round_robin();
    test_slow_slave();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
